// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA datapath blocks around the FME core:
//   - fsm_state_e : arbiter FSM encoding (IDLE/LAUNCH/WAIT/RETIRE, 2 bits)
//   - OWNER_ENC / OWNER_DEC : owner/grant encoding (0 = encrypt, 1 = decrypt)
//   - DEF_WIDTH : default operand/result width
// ----------------------------------------------------------------------------
package rsa_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic OWNER_ENC = 1'b0;
    localparam logic OWNER_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } fsm_state_e;

endpackage : rsa_pkg

// File: rtl/fme_arbiter_if.sv
// ----------------------------------------------------------------------------
// fme_arbiter_if
// Bundles every signal of the FME arbiter except clock and reset.
//   requester side : enc_* / dec_* (req + operands in, done out),
//                    result, err, busy, owner
//   core side      : fme_start, fme_base/exp/mod out; fme_done, fme_result in
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters and FME core)
// ----------------------------------------------------------------------------
interface fme_arbiter_if #(
    parameter int WIDTH = rsa_pkg::DEF_WIDTH
);
    // Encrypt requester (port 0)
    logic             enc_req;
    logic [WIDTH-1:0] enc_base;
    logic [WIDTH-1:0] enc_exp;
    logic [WIDTH-1:0] enc_mod;
    logic             enc_done;

    // Decrypt requester (port 1)
    logic             dec_req;
    logic [WIDTH-1:0] dec_base;
    logic [WIDTH-1:0] dec_exp;
    logic [WIDTH-1:0] dec_mod;
    logic             dec_done;

    // Shared return path and status
    logic [WIDTH-1:0] result;
    logic             err;
    logic             busy;
    logic             owner;

    // FME core
    logic             fme_start;
    logic [WIDTH-1:0] fme_base;
    logic [WIDTH-1:0] fme_exp;
    logic [WIDTH-1:0] fme_mod;
    logic             fme_done;
    logic [WIDTH-1:0] fme_result;

    modport slave (
        input  enc_req, enc_base, enc_exp, enc_mod,
        input  dec_req, dec_base, dec_exp, dec_mod,
        input  fme_done, fme_result,
        output enc_done, dec_done, result, err, busy, owner,
        output fme_start, fme_base, fme_exp, fme_mod
    );

    modport master (
        output enc_req, enc_base, enc_exp, enc_mod,
        output dec_req, dec_base, dec_exp, dec_mod,
        output fme_done, fme_result,
        input  enc_done, dec_done, result, err, busy, owner,
        input  fme_start, fme_base, fme_exp, fme_mod
    );

endinterface : fme_arbiter_if

// File: rtl/fme_arbiter_rr_grant2.sv
// ----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin grant.
//   req0_i  : request from port 0
//   req1_i  : request from port 1
//   last_i  : port that was served last
//   gnt_o   : winning port (only meaningful when any_o = 1)
//   any_o   : at least one request is present
// A lone request always wins; on a tie the port that was not served last wins.
// ----------------------------------------------------------------------------
module rr_grant2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gnt_o,
    output logic any_o
);

    always_comb begin
        any_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_o = ~last_i;
        end else begin
            gnt_o = req1_i;
        end
    end

endmodule : rr_grant2

// File: rtl/fme_arbiter.sv
// ----------------------------------------------------------------------------
// fme_arbiter
// Shares one fast-modular-exponentiation core between the encrypt path
// (port 0, enc_*) and the decrypt path (port 1, dec_*). Picks a requester,
// registers its operands onto fme_*, pulses fme_start, waits for fme_done
// (bounded by a watchdog) and returns result/err with a one-cycle done pulse
// on the owner's port.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (shared with the FME core)
//   arb_if  : fme_arbiter_if.slave - requester and core signals
// Parameters:
//   WIDTH   : operand/result width; must match arb_if's WIDTH
//   TIMEOUT : WAIT cycles allowed before the job is aborted (>= 2)
// ----------------------------------------------------------------------------
module fme_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    fme_arbiter_if.slave  arb_if
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fsm_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic             gnt;
    logic             any_req;
    logic [WIDTH-1:0] sel_base;
    logic [WIDTH-1:0] sel_exp;
    logic [WIDTH-1:0] sel_mod;

    rr_grant2 u_rr_grant2 (
        .req0_i (arb_if.enc_req),
        .req1_i (arb_if.dec_req),
        .last_i (last_owner_q),
        .gnt_o  (gnt),
        .any_o  (any_req)
    );

    // Operands of whichever port would win this cycle; only captured in IDLE,
    // so a non-owner's operands are never sampled mid-job.
    assign sel_base = (gnt == OWNER_DEC) ? arb_if.dec_base : arb_if.enc_base;
    assign sel_exp  = (gnt == OWNER_DEC) ? arb_if.dec_exp  : arb_if.enc_exp;
    assign sel_mod  = (gnt == OWNER_DEC) ? arb_if.dec_mod  : arb_if.enc_mod;

    always_comb begin
        // NOTE: every next-state value takes its hold value first, so no path
        // through the case statement leaves a signal unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        base_d       = base_q;
        exp_d        = exp_q;
        mod_d        = mod_q;
        result_d     = result_q;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = gnt;
                    base_d  = sel_base;
                    exp_d   = sel_exp;
                    mod_d   = sel_mod;
                    // x mod 0 is undefined: abort without ever starting the core.
                    if (sel_mod == '0) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RETIRE;
                    end else begin
                        state_d  = ST_LAUNCH;
                    end
                end
            end

            ST_LAUNCH: begin
                count_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // fme_done is only honoured here; late or spurious pulses in
                // any other state fall through untouched.
                if (arb_if.fme_done) begin
                    result_d = arb_if.fme_result;
                    err_d    = 1'b0;
                    state_d  = ST_RETIRE;
                end else if (count_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RETIRE;
                end else begin
                    count_d  = count_q + 1'b1;
                end
            end

            ST_RETIRE: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state is reset here, including the wide operand and
            // result registers, because they drive ports that must read 0
            // straight after reset.
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_ENC;
            last_owner_q <= OWNER_DEC;
            count_q      <= '0;
            base_q       <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
            base_q       <= base_d;
            exp_q        <= exp_d;
            mod_q        <= mod_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Moore outputs
    assign arb_if.fme_start = (state_q == ST_LAUNCH);
    assign arb_if.enc_done  = (state_q == ST_RETIRE) && (owner_q == OWNER_ENC);
    assign arb_if.dec_done  = (state_q == ST_RETIRE) && (owner_q == OWNER_DEC);
    assign arb_if.busy      = (state_q != ST_IDLE);
    assign arb_if.owner     = owner_q;
    assign arb_if.fme_base  = base_q;
    assign arb_if.fme_exp   = exp_q;
    assign arb_if.fme_mod   = mod_q;
    assign arb_if.result    = result_q;
    assign arb_if.err       = err_q;

endmodule : fme_arbiter

// File: tb/tb_fme_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fme_arbiter
// Directed bench for fme_arbiter with a behavioural FME core (base^exp mod m
// after a programmable delay, or never when hung). Stimulus pushes the
// hand-computed response of each job into a scoreboard queue; a monitor pops
// and compares whenever enc_done or dec_done is seen. Timing, reset and
// boundary behaviour are checked inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_fme_arbiter;
    import rsa_pkg::*;

    localparam int W  = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fme_arbiter_if #(.WIDTH(W)) bus ();

    logic         core_done;
    logic         inj_done;
    logic [W-1:0] core_result;
    assign bus.fme_done   = core_done | inj_done;
    assign bus.fme_result = core_result;

    fme_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus.slave)
    );

    typedef struct {
        logic         port;
        logic [W-1:0] result;
        logic         err;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks      = 0;
    int           errors      = 0;
    int           enc_pulses  = 0;
    int           dec_pulses  = 0;
    int           core_starts = 0;
    int           core_delay  = 1;
    bit           core_hang   = 1'b0;
    int           core_cnt    = -1;
    logic [W-1:0] core_pend   = '0;
    int           n, ep, dp;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [63:0]  r;
        logic [63:0]  x;
        logic [W-1:0] k;
        if (m == '0) return '0;
        r = 64'(1) % 64'(m);
        x = 64'(b) % 64'(m);
        k = e;
        while (k != '0) begin
            if (k[0]) r = (r * x) % 64'(m);
            x = (x * x) % 64'(m);
            k = k >> 1;
        end
        return r[W-1:0];
    endfunction

    // Behavioural FME core: fme_done rises core_delay cycles after the
    // fme_start cycle. Shares rst_n, so a reset drops any pending job.
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (!rst_n) begin
                core_cnt = -1;
            end else begin
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        core_done   = 1'b1;
                        core_result = core_pend;
                        core_cnt    = -1;
                    end
                end
                if (bus.fme_start) begin
                    core_starts++;
                    core_pend = modexp(bus.fme_base, bus.fme_exp, bus.fme_mod);
                    core_cnt  = core_hang ? -1 : core_delay;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (bus.enc_done || bus.dec_done)) begin
                if (bus.enc_done) enc_pulses++;
                if (bus.dec_done) dec_pulses++;
                check("done_onehot", W'(bus.enc_done & bus.dec_done), '0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got enc_done=%0b dec_done=%0b, want no done",
                             bus.enc_done, bus.dec_done);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("done_port",   W'(bus.dec_done), W'(mon_e.port));
                    check("done_result", bus.result,       mon_e.result);
                    check("done_err",    W'(bus.err),      W'(mon_e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit hit(input int what);
        if (what == 0) return bus.enc_done | bus.dec_done;
        return bus.fme_start;
    endfunction

    // what: 0 = any done pulse, 1 = fme_start. Returns cycles waited.
    task automatic wait_for(input string name, input int what, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!hit(what) && cyc < budget);
        if (!hit(what)) begin
            checks++;
            errors++;
            $display("FAIL %s: got no event in %0d cycles, want event", name, budget);
        end
    endtask

    task automatic drive_enc(input logic req, input logic [W-1:0] b, input logic [W-1:0] e,
                             input logic [W-1:0] m);
        bus.enc_base = b;
        bus.enc_exp  = e;
        bus.enc_mod  = m;
        bus.enc_req  = req;
    endtask

    task automatic drive_dec(input logic req, input logic [W-1:0] b, input logic [W-1:0] e,
                             input logic [W-1:0] m);
        bus.dec_base = b;
        bus.dec_exp  = e;
        bus.dec_mod  = m;
        bus.dec_req  = req;
    endtask

    task automatic push(input logic port, input logic [W-1:0] res, input logic e);
        exp_t x;
        x.port   = port;
        x.result = res;
        x.err    = e;
        sb_q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.enc_req = 1'b0;
        bus.dec_req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        inj_done = 1'b0;
        drive_enc(1'b0, '0, '0, '0);
        drive_dec(1'b0, '0, '0, '0);
        repeat (2) tick();

        // Reset values
        check("rst_busy",      W'(bus.busy),      '0);
        check("rst_owner",     W'(bus.owner),     '0);
        check("rst_result",    bus.result,        '0);
        check("rst_err",       W'(bus.err),       '0);
        check("rst_fme_start", W'(bus.fme_start), '0);
        check("rst_fme_base",  bus.fme_base,      '0);
        check("rst_fme_mod",   bus.fme_mod,       '0);
        check("rst_enc_done",  W'(bus.enc_done),  '0);
        check("rst_dec_done",  W'(bus.dec_done),  '0);
        rst_n = 1'b1;
        tick();

        // 1. enc only: 5^3 mod 33 = 26, core delay 10
        dp         = dec_pulses;
        core_delay = 10;
        drive_enc(1'b1, 5, 3, 33);
        push(OWNER_ENC, 26, 1'b0);
        tick();
        check("t1_start",    W'(bus.fme_start), 1);
        check("t1_owner",    W'(bus.owner),     0);
        check("t1_fme_exp",  bus.fme_exp,       3);
        check("t1_fme_mod",  bus.fme_mod,       33);
        wait_for("t1_done", 0, 40, n);
        check("t1_done_lat", n, 11);
        check("t1_enc_done", W'(bus.enc_done), 1);
        bus.enc_req = 1'b0;
        tick();
        check("t1_idle",    W'(bus.busy),   0);
        check("t1_hold",    bus.result,     26);
        check("t1_no_dec",  dec_pulses - dp, 0);

        // 2. tie after reset: enc (7^2 mod 10 = 9) then dec (3^4 mod 7 = 4)
        do_reset();
        core_delay = 3;
        drive_enc(1'b1, 7, 2, 10);
        drive_dec(1'b1, 3, 4, 7);
        push(OWNER_ENC, 9, 1'b0);
        push(OWNER_DEC, 4, 1'b0);
        tick();
        check("t2_tie1_owner", W'(bus.owner), 0);
        check("t2_tie1_base",  bus.fme_base,  7);
        wait_for("t2_enc_done", 0, 40, n);
        check("t2_enc_done", W'(bus.enc_done), 1);
        bus.enc_req = 1'b0;
        wait_for("t2_dec_start", 1, 10, n);
        check("t2_turnaround", n, 2);
        check("t2_dec_owner",  W'(bus.owner), 1);
        check("t2_dec_base",   bus.fme_base,  3);
        wait_for("t2_dec_done", 0, 40, n);
        check("t2_dec_done", W'(bus.dec_done), 1);
        bus.dec_req = 1'b0;
        tick();
        // enc-only job (2^3 mod 5 = 3) leaves enc as last owner
        drive_enc(1'b1, 2, 3, 5);
        push(OWNER_ENC, 3, 1'b0);
        wait_for("t2_solo_done", 0, 40, n);
        bus.enc_req = 1'b0;
        tick();
        // Tie again: dec first (5^2 mod 9 = 7), then enc (3^3 mod 7 = 6)
        ep = enc_pulses;
        dp = dec_pulses;
        drive_enc(1'b1, 3, 3, 7);
        drive_dec(1'b1, 5, 2, 9);
        push(OWNER_DEC, 7, 1'b0);
        push(OWNER_ENC, 6, 1'b0);
        tick();
        check("t2_tie2_owner", W'(bus.owner), 1);
        wait_for("t2_tie2_first", 0, 40, n);
        check("t2_tie2_dec_done", W'(bus.dec_done), 1);
        bus.dec_req = 1'b0;
        wait_for("t2_tie2_second", 0, 40, n);
        check("t2_tie2_enc_done", W'(bus.enc_done), 1);
        bus.enc_req = 1'b0;
        tick();
        check("t2_enc_once", enc_pulses - ep, 1);
        check("t2_dec_once", dec_pulses - dp, 1);

        // 3. dec with mod = 0: aborted without starting the core
        ep = core_starts;
        drive_dec(1'b1, 9, 9, 0);
        push(OWNER_DEC, 0, 1'b1);
        tick();
        check("t3_no_start", W'(bus.fme_start), 0);
        check("t3_dec_done", W'(bus.dec_done),  1);
        check("t3_err",      W'(bus.err),       1);
        check("t3_result",   bus.result,        0);
        bus.dec_req = 1'b0;
        tick();
        check("t3_idle",        W'(bus.busy), 0);
        check("t3_err_hold",    W'(bus.err),  1);
        check("t3_core_unused", core_starts - ep, 0);

        // 4. watchdog: LAUNCH clears count, WAIT runs counts 0..TO-1, then RETIRE
        core_hang = 1'b1;
        drive_enc(1'b1, 2, 5, 13);
        push(OWNER_ENC, 0, 1'b1);
        tick();
        check("t4_start", W'(bus.fme_start), 1);
        wait_for("t4_timeout", 0, 40, n);
        check("t4_timeout_lat", n, TO + 1);
        bus.enc_req = 1'b0;
        tick();
        // Late fme_done in IDLE
        ep       = enc_pulses;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        check("t4_late_busy",   W'(bus.busy), 0);
        check("t4_late_nodone", enc_pulses - ep, 0);
        check("t4_err_hold",    W'(bus.err), 1);
        check("t4_res_hold",    bus.result,  0);
        // Next job (4^13 mod 497 = 445) with a spurious fme_done during LAUNCH
        core_hang  = 1'b0;
        core_delay = 4;
        drive_enc(1'b1, 4, 13, 497);
        push(OWNER_ENC, 445, 1'b0);
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        wait_for("t4_next_done", 0, 40, n);
        check("t4_next_lat", n, 4);
        bus.enc_req = 1'b0;
        tick();

        // 5. asynchronous reset three cycles into WAIT
        core_delay = 10;
        drive_enc(1'b1, 6, 2, 11);
        tick();
        repeat (3) tick();
        check("t5_in_wait", W'(bus.busy), 1);
        #3;
        rst_n       = 1'b0;
        bus.enc_req = 1'b0;
        #2;
        check("t5_busy",      W'(bus.busy),      0);
        check("t5_fme_start", W'(bus.fme_start), 0);
        check("t5_result",    bus.result,        0);
        check("t5_fme_base",  bus.fme_base,      0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // First tie after reset goes to enc (6^2 mod 11 = 3), then dec (2^10 mod 1000 = 24)
        core_delay = 2;
        drive_enc(1'b1, 6, 2, 11);
        drive_dec(1'b1, 2, 10, 1000);
        push(OWNER_ENC, 3, 1'b0);
        push(OWNER_DEC, 24, 1'b0);
        tick();
        check("t5_tie_owner", W'(bus.owner), 0);
        wait_for("t5_first", 0, 40, n);
        bus.enc_req = 1'b0;
        wait_for("t5_second", 0, 40, n);
        bus.dec_req = 1'b0;
        tick();

        // 6. dec drops req mid-job (3^5 mod 100 = 43); enc requests meanwhile (8^1 mod 5 = 3)
        dp         = dec_pulses;
        core_delay = 8;
        drive_dec(1'b1, 3, 5, 100);
        push(OWNER_DEC, 43, 1'b0);
        tick();
        check("t6_start", W'(bus.fme_start), 1);
        check("t6_owner", W'(bus.owner),     1);
        tick();
        bus.dec_req = 1'b0;
        drive_enc(1'b1, 8, 1, 5);
        push(OWNER_ENC, 3, 1'b0);
        wait_for("t6_dec_done", 0, 40, n);
        check("t6_done_lat",  n, 8);
        check("t6_dec_done",  W'(bus.dec_done), 1);
        check("t6_base_kept", bus.fme_base, 3);
        wait_for("t6_enc_start", 1, 10, n);
        check("t6_enc_start_lat", n, 2);
        check("t6_enc_owner",     W'(bus.owner), 0);
        check("t6_enc_base",      bus.fme_base,  8);
        wait_for("t6_enc_done", 0, 40, n);
        bus.enc_req = 1'b0;
        tick();
        check("t6_dec_once", dec_pulses - dp, 1);

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fme_arbiter
